// File: rtl/psum_writeback_collector_pkg.sv
// -----------------------------------------------------------------------------
// psum_pkg
// Shared definitions for the psum receive path. The index generator and the
// writeback collector both import this package, so the default loop-dimension
// widths stay identical on both sides of the PE array.
//
// Contents:
//   PSUM_*_WIDTH       default widths for data, loop dimensions and addresses
//   PSUM_FIFO_DEPTH    default collector FIFO depth
//   collector_state_e  writeback collector state encoding
// -----------------------------------------------------------------------------
package psum_pkg;

  localparam int PSUM_DATA_WIDTH = 16;
  localparam int PSUM_F_WIDTH    = 6;
  localparam int PSUM_N_WIDTH    = 3;
  localparam int PSUM_E_WIDTH    = 8;
  localparam int PSUM_P_WIDTH    = 5;
  localparam int PSUM_T_WIDTH    = 3;
  localparam int PSUM_ADDR_WIDTH = 25;
  localparam int PSUM_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } collector_state_e;

endpackage

// File: rtl/psum_writeback_collector_if.sv
// -----------------------------------------------------------------------------
// psum_writeback_collector_if
// Bundles the two streaming sides of the collector:
//   psum input  : psum_in_valid / psum_in_data / psum_in_ready from the PE array
//   throttle    : await back to the index generator
//   write port  : wr_en / wr_ready / wr_addr / wr_data to the global psum buffer
//   indices     : psum/channel/row/col indices of the write currently offered
//
// Modports:
//   master : the collector (accepts psums, drives the buffer write port)
//   slave  : the environment (PE array, index generator, psum buffer)
// -----------------------------------------------------------------------------
interface psum_writeback_collector_if
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int F_WIDTH    = PSUM_F_WIDTH,
  parameter int n_WIDTH    = PSUM_N_WIDTH,
  parameter int e_WIDTH    = PSUM_E_WIDTH,
  parameter int p_WIDTH    = PSUM_P_WIDTH,
  parameter int t_WIDTH    = PSUM_T_WIDTH,
  parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH
);

  logic                       psum_in_valid;
  logic [DATA_WIDTH-1:0]      psum_in_data;
  logic                       psum_in_ready;
  logic                       await;
  logic                       wr_en;
  logic                       wr_ready;
  logic [ADDR_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [n_WIDTH-1:0]         psum_index;
  logic [p_WIDTH+t_WIDTH-1:0] channel_index;
  logic [e_WIDTH-1:0]         row_index;
  logic [F_WIDTH-1:0]         col_index;

  modport master (
    input  psum_in_valid, psum_in_data, wr_ready,
    output psum_in_ready, await, wr_en, wr_addr, wr_data,
           psum_index, channel_index, row_index, col_index
  );

  modport slave (
    output psum_in_valid, psum_in_data, wr_ready,
    input  psum_in_ready, await, wr_en, wr_addr, wr_data,
           psum_index, channel_index, row_index, col_index
  );

endinterface

// File: rtl/psum_writeback_collector_fifo.sv
// -----------------------------------------------------------------------------
// psum_fifo
// Small synchronous FIFO buffering psums between the PE array and the global
// psum buffer. Updates on the falling clock edge like the rest of the collector.
// FIFO_DEPTH must be a power of two (pointers wrap naturally) and >= 2.
//
// Ports:
//   clk, reset_n  falling-edge clock, asynchronous active-low reset
//   push          write push_data at the tail (never asserted while full)
//   push_data     data to enqueue
//   pop           drop the head entry (never asserted while empty)
//   head          current head entry (undefined while empty)
//   full, empty   occupancy flags
//   count         number of valid entries
// -----------------------------------------------------------------------------
module psum_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and the consumer masks the head while the FIFO is empty.
  always_ff @(negedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  a_no_push_full: assert property (@(negedge clk) disable iff (!reset_n) !(push && full));
  a_no_pop_empty: assert property (@(negedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/psum_writeback_collector.sv
// -----------------------------------------------------------------------------
// psum_writeback_collector
// Receive end of the psum path. Psums streamed out of the PE array are queued
// in a small FIFO and written to the global psum buffer at consecutive linear
// addresses. Each write carries its (psum, channel, row, col) indices, derived
// from the same loop nest the index generator walks:
//   innermost -> outermost : p_idx, F_idx, n_idx, t_idx, e_idx
// so wr_addr == (((e_idx*t+t_idx)*n+n_idx)*F+F_idx)*p+p_idx by construction.
// await (FIFO full) throttles the index generator.
// All state updates on the falling clock edge, matching NoC controller timing.
//
// Ports:
//   clk, reset_n   falling-edge clock, asynchronous active-low reset
//   start          begin a job (sampled only in IDLE)
//   F, n, e, p, t  loop dimensions (latched at start)
//   busy           job in progress (LOAD/RUN/DRAIN)
//   done           one-cycle completion pulse
//   bus            psum input, await, buffer write port and write indices
// -----------------------------------------------------------------------------
module psum_writeback_collector
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
  parameter int F_WIDTH    = PSUM_F_WIDTH,
  parameter int n_WIDTH    = PSUM_N_WIDTH,
  parameter int e_WIDTH    = PSUM_E_WIDTH,
  parameter int p_WIDTH    = PSUM_P_WIDTH,
  parameter int t_WIDTH    = PSUM_T_WIDTH,
  parameter int ADDR_WIDTH = PSUM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = PSUM_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [F_WIDTH-1:0] F,
  input  logic [n_WIDTH-1:0] n,
  input  logic [e_WIDTH-1:0] e,
  input  logic [p_WIDTH-1:0] p,
  input  logic [t_WIDTH-1:0] t,
  output logic               busy,
  output logic               done,
  psum_writeback_collector_if.master bus
);

  localparam int CH_WIDTH = p_WIDTH + t_WIDTH;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  collector_state_e state, state_next;

  // Latched job configuration.
  logic [F_WIDTH-1:0] f_cfg;
  logic [n_WIDTH-1:0] n_cfg;
  logic [e_WIDTH-1:0] e_cfg;
  logic [p_WIDTH-1:0] p_cfg;
  logic [t_WIDTH-1:0] t_cfg;

  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] total_calc;
  logic [ADDR_WIDTH-1:0] in_cnt;
  logic [ADDR_WIDTH-1:0] wr_cnt;

  // Loop-nest position of the write currently at the FIFO head.
  logic [p_WIDTH-1:0] p_idx;
  logic [F_WIDTH-1:0] f_idx;
  logic [n_WIDTH-1:0] n_idx;
  logic [t_WIDTH-1:0] t_idx;
  logic [e_WIDTH-1:0] e_idx;

  logic [p_WIDTH-1:0] p_last;
  logic [F_WIDTH-1:0] f_last;
  logic [n_WIDTH-1:0] n_last;
  logic [t_WIDTH-1:0] t_last;
  logic [e_WIDTH-1:0] e_last;

  logic                  accept_ok;
  logic                  write_ok;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  // Product of the latched dimensions, truncated to the address width.
  assign total_calc = ADDR_WIDTH'(e_cfg) * ADDR_WIDTH'(t_cfg) * ADDR_WIDTH'(n_cfg)
                    * ADDR_WIDTH'(f_cfg) * ADDR_WIDTH'(p_cfg);

  assign push     = bus.psum_in_valid && accept_ok;
  assign pop      = write_ok && bus.wr_ready;
  assign last_pop = pop && (wr_cnt == total - 1'b1);

  assign p_last = p_cfg - 1'b1;
  assign f_last = f_cfg - 1'b1;
  assign n_last = n_cfg - 1'b1;
  assign t_last = t_cfg - 1'b1;
  assign e_last = e_cfg - 1'b1;

  psum_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (bus.psum_in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // The last write may complete while still in RUN (the final psum was popped
  // in the cycle right after it was accepted); in that case DRAIN would never
  // see a handshake, so RUN goes straight to DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves a variable unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = (total_calc == '0) ? DONE : RUN;
      RUN:     if (in_cnt == total) state_next = last_pop ? DONE : DRAIN;
      DRAIN:   if (last_pop) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    accept_ok = 1'b0;
    write_ok  = 1'b0;
    case (state)
      LOAD:  busy = 1'b1;
      RUN: begin
        busy      = 1'b1;
        accept_ok = !fifo_full && (in_cnt < total);
        write_ok  = !fifo_empty;
      end
      DRAIN: begin
        busy     = 1'b1;
        write_ok = !fifo_empty;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: configuration, counters and loop-nest indices
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_cfg  <= '0;
      n_cfg  <= '0;
      e_cfg  <= '0;
      p_cfg  <= '0;
      t_cfg  <= '0;
      total  <= '0;
      in_cnt <= '0;
      wr_cnt <= '0;
      p_idx  <= '0;
      f_idx  <= '0;
      n_idx  <= '0;
      t_idx  <= '0;
      e_idx  <= '0;
    end else begin
      if (state == IDLE && start) begin
        f_cfg  <= F;
        n_cfg  <= n;
        e_cfg  <= e;
        p_cfg  <= p;
        t_cfg  <= t;
        in_cnt <= '0;
        wr_cnt <= '0;
        p_idx  <= '0;
        f_idx  <= '0;
        n_idx  <= '0;
        t_idx  <= '0;
        e_idx  <= '0;
      end

      if (state == LOAD) total <= total_calc;

      if (push) in_cnt <= in_cnt + 1'b1;

      if (pop) begin
        wr_cnt <= wr_cnt + 1'b1;
        // Odometer walk: each level wraps at dim-1 and carries outward.
        if (p_idx == p_last) begin
          p_idx <= '0;
          if (f_idx == f_last) begin
            f_idx <= '0;
            if (n_idx == n_last) begin
              n_idx <= '0;
              if (t_idx == t_last) begin
                t_idx <= '0;
                e_idx <= (e_idx == e_last) ? '0 : e_idx + 1'b1;
              end else begin
                t_idx <= t_idx + 1'b1;
              end
            end else begin
              n_idx <= n_idx + 1'b1;
            end
          end else begin
            f_idx <= f_idx + 1'b1;
          end
        end else begin
          p_idx <= p_idx + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interface outputs
  // The FIFO head is masked while no write is offered so the data bus reads 0
  // after reset and between jobs instead of stale or uninitialised storage.
  // ---------------------------------------------------------------------------
  assign bus.psum_in_ready = accept_ok;
  assign bus.await         = fifo_full;
  assign bus.wr_en         = write_ok;
  assign bus.wr_addr       = wr_cnt;
  assign bus.wr_data       = write_ok ? fifo_head : '0;
  assign bus.psum_index    = n_idx;
  assign bus.row_index     = e_idx;
  assign bus.col_index     = f_idx;
  assign bus.channel_index = CH_WIDTH'(p_idx) + CH_WIDTH'(t_idx) * CH_WIDTH'(p_cfg);

  a_count_bound: assert property (@(negedge clk) disable iff (!reset_n)
                                  fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_psum_writeback_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_writeback_collector
// Self-checking bench for psum_writeback_collector. A job-level reference
// model (queue of accepted psums, counts of accepted/written words, and the
// write index decomposed from the linear write number by div/mod) predicts
// every output on each rising edge, midway between the DUT's falling edges.
// Directed jobs add literal expectations; randomized jobs follow.
// -----------------------------------------------------------------------------
module tb_psum_writeback_collector;
  import psum_pkg::*;

  localparam int DW    = PSUM_DATA_WIDTH;
  localparam int DEPTH = PSUM_FIFO_DEPTH;
  localparam longint ADDR_MASK = (longint'(1) << PSUM_ADDR_WIDTH) - 1;

  typedef enum int {M_IDLE, M_LOAD, M_ACTIVE, M_DONE} model_phase_e;

  logic clk;
  logic reset_n;
  logic start;
  logic [PSUM_F_WIDTH-1:0] cfg_f;
  logic [PSUM_N_WIDTH-1:0] cfg_n;
  logic [PSUM_E_WIDTH-1:0] cfg_e;
  logic [PSUM_P_WIDTH-1:0] cfg_p;
  logic [PSUM_T_WIDTH-1:0] cfg_t;
  logic busy;
  logic done;

  psum_writeback_collector_if bus ();

  psum_writeback_collector dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .F       (cfg_f),
    .n       (cfg_n),
    .e       (cfg_e),
    .p       (cfg_p),
    .t       (cfg_t),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  model_phase_e m_phase = M_IDLE;
  logic [DW-1:0] mq[$];
  longint m_total = 0;
  longint m_acc = 0;
  longint m_wr = 0;
  longint m_f = 0, m_n = 0, m_e = 0, m_p = 0, m_t = 0;

  // ---------------- observation of the DUT ----------------
  int cyc = 0;
  int dut_acc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;
  int busy_cyc = 0;
  logic [63:0] log_addr[$];
  logic [63:0] log_data[$];
  logic [63:0] log_row[$];
  logic [63:0] log_col[$];
  logic [63:0] log_chan[$];
  logic src_taken = 1'b0;

  always @(posedge clk) begin
    logic exp_ready, exp_wr_en, exp_await, exp_busy, exp_done, popped_last;
    longint k, pi, fi, ni, ti, ei;
    cyc++;
    if (!reset_n) begin
      m_phase = M_IDLE;
      mq.delete();
      m_acc = 0;
      m_wr  = 0;
    end
    exp_ready = (m_phase == M_ACTIVE) && (m_acc < m_total) && (mq.size() < DEPTH);
    exp_wr_en = (m_phase == M_ACTIVE) && (mq.size() > 0);
    exp_await = (mq.size() == DEPTH);
    exp_busy  = (m_phase == M_LOAD) || (m_phase == M_ACTIVE);
    exp_done  = (m_phase == M_DONE);

    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("psum_in_ready", bus.psum_in_ready, exp_ready);
    check("await", bus.await, exp_await);
    check("wr_en", bus.wr_en, exp_wr_en);
    if (exp_wr_en) begin
      k  = m_wr;
      pi = k % m_p;
      fi = (k / m_p) % m_f;
      ni = (k / (m_p * m_f)) % m_n;
      ti = (k / (m_p * m_f * m_n)) % m_t;
      ei = k / (m_p * m_f * m_n * m_t);
      check("wr_addr", bus.wr_addr, k);
      check("wr_data", bus.wr_data, mq[0]);
      check("psum_index", bus.psum_index, ni);
      check("channel_index", bus.channel_index, pi + ti * m_p);
      check("row_index", bus.row_index, ei);
      check("col_index", bus.col_index, fi);
    end else if (!reset_n) begin
      check("wr_addr_rst", bus.wr_addr, 0);
      check("wr_data_rst", bus.wr_data, 0);
    end

    // record what the DUT does at the coming falling edge
    src_taken = bus.psum_in_valid && bus.psum_in_ready;
    if (src_taken) dut_acc++;
    if (bus.wr_en && bus.wr_ready) begin
      log_addr.push_back(64'(bus.wr_addr));
      log_data.push_back(64'(bus.wr_data));
      log_row.push_back(64'(bus.row_index));
      log_col.push_back(64'(bus.col_index));
      log_chan.push_back(64'(bus.channel_index));
      last_wr_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cyc++;
    if (start) start_cyc = cyc;

    // advance the model to the state after the coming falling edge
    if (reset_n) begin
      popped_last = 1'b0;
      if (exp_wr_en && bus.wr_ready) begin
        void'(mq.pop_front());
        m_wr++;
        popped_last = (m_wr == m_total);
      end
      if (exp_ready && bus.psum_in_valid) begin
        mq.push_back(bus.psum_in_data);
        m_acc++;
      end
      case (m_phase)
        M_IDLE: if (start) begin
          m_f = cfg_f; m_n = cfg_n; m_e = cfg_e; m_p = cfg_p; m_t = cfg_t;
          m_total = (m_e * m_t * m_n * m_f * m_p) & ADDR_MASK;
          m_acc = 0;
          m_wr  = 0;
          m_phase = M_LOAD;
        end
        M_LOAD:   m_phase = (m_total == 0) ? M_DONE : M_ACTIVE;
        M_ACTIVE: if (popped_last) m_phase = M_DONE;
        default:  m_phase = M_IDLE;
      endcase
    end
  end

  // ---------------- psum source and buffer sink ----------------
  int src_mode = 0;       // 0: valid whenever data remains, 1: random valid
  int src_limit = 0;      // number of psums the source offers
  int src_sent = 0;
  int src_rand_data = 0;
  logic [DW-1:0] src_data = '0;
  int sink_mode = 0;      // 0: always ready, 1: never ready, 2: random

  always begin
    @(negedge clk);
    #2;
    if (src_taken) begin
      src_sent++;
      src_data = (src_rand_data != 0) ? DW'($urandom) : src_data + 1'b1;
    end
    if (src_sent >= src_limit)  bus.psum_in_valid = 1'b0;
    else if (src_mode == 0)     bus.psum_in_valid = 1'b1;
    else                        bus.psum_in_valid = 1'($urandom_range(0, 1));
    bus.psum_in_data = src_data;
    case (sink_mode)
      0:       bus.wr_ready = 1'b1;
      1:       bus.wr_ready = 1'b0;
      default: bus.wr_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- helpers ----------------
  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic setup_source(input int limit, input int mode, input logic [DW-1:0] first,
                              input int rnd);
    src_limit = limit;
    src_sent = 0;
    src_mode = mode;
    src_data = first;
    src_rand_data = rnd;
    dut_acc = 0;
    log_addr.delete(); log_data.delete(); log_row.delete();
    log_col.delete(); log_chan.delete();
  endtask

  task automatic start_job(input int f, input int nn, input int ee, input int pp, input int tt);
    tick(1);
    cfg_f = PSUM_F_WIDTH'(f); cfg_n = PSUM_N_WIDTH'(nn); cfg_e = PSUM_E_WIDTH'(ee);
    cfg_p = PSUM_P_WIDTH'(pp); cfg_t = PSUM_T_WIDTH'(tt);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    // scramble configuration: it must be ignored once latched
    cfg_f = PSUM_F_WIDTH'($urandom); cfg_n = PSUM_N_WIDTH'($urandom);
    cfg_e = PSUM_E_WIDTH'($urandom); cfg_p = PSUM_P_WIDTH'($urandom);
    cfg_t = PSUM_T_WIDTH'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick(1);
    check(name, done_cnt > d0, 1);
    tick(2);
    check({name, "_single_pulse"}, done_cnt, d0 + 1);
  endtask

  // ---------------- tests ----------------
  initial begin
    int d0;
    reset_n = 1'b1;
    start = 1'b0;
    cfg_f = '0; cfg_n = '0; cfg_e = '0; cfg_p = '0; cfg_t = '0;
    bus.psum_in_valid = 1'b0;
    bus.psum_in_data = '0;
    bus.wr_ready = 1'b0;
    #1 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    check("idle_busy", busy, 0);

    // Basic job: 8 psums back to back, buffer always ready.
    sink_mode = 0;
    setup_source(8, 0, 16'h0010, 0);
    d0 = done_cnt;
    start_job(2, 1, 2, 2, 1);
    wait_done(d0, 100, "basic_done");
    check("basic_writes", log_data.size(), 8);
    begin
      logic [63:0] rows[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      logic [63:0] cols[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
      logic [63:0] chns[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
      for (int k = 0; k < 8 && k < log_data.size(); k++) begin
        check("basic_addr", log_addr[k], k);
        check("basic_data", log_data[k], 64'h10 + k);
        check("basic_row", log_row[k], rows[k]);
        check("basic_col", log_col[k], cols[k]);
        check("basic_chan", log_chan[k], chns[k]);
      end
    end
    check("basic_done_latency", done_cyc - last_wr_cyc, 1);

    // Backpressure: buffer stalled, source streams continuously.
    sink_mode = 1;
    setup_source(8, 0, 16'h0020, 0);
    d0 = done_cnt;
    start_job(2, 1, 2, 2, 1);
    tick(10);
    check("bp_accepted", dut_acc, DEPTH);
    check("bp_await", bus.await, 1);
    check("bp_ready_low", bus.psum_in_ready, 0);
    sink_mode = 0;
    wait_done(d0, 100, "bp_done");
    check("bp_writes", log_data.size(), 8);
    for (int k = 0; k < log_data.size(); k++) check("bp_data_order", log_data[k], 64'h20 + k);

    // Multi-pass channel numbering.
    setup_source(6, 0, 16'h0100, 0);
    d0 = done_cnt;
    start_job(1, 1, 1, 3, 2);
    wait_done(d0, 100, "mp_done");
    check("mp_writes", log_chan.size(), 6);
    for (int k = 0; k < log_chan.size(); k++) begin
      check("mp_chan", log_chan[k], k);
      check("mp_addr", log_addr[k], k);
    end

    // Zero dimension: LOAD then DONE, no writes.
    setup_source(4, 0, 16'h0200, 0);
    busy_cyc = 0;
    d0 = done_cnt;
    start_job(2, 1, 2, 0, 1);
    wait_done(d0, 20, "zero_done");
    check("zero_writes", log_data.size(), 0);
    check("zero_accepts", dut_acc, 0);
    check("zero_done_latency", done_cyc - start_cyc, 2);
    check("zero_busy_cycles", busy_cyc, 1);

    // Overrun: 6 offered for a job of 4; a start during RUN is ignored.
    setup_source(6, 0, 16'h0300, 0);
    d0 = done_cnt;
    start_job(2, 1, 1, 2, 1);
    tick(1);
    cfg_p = 5; cfg_f = 7; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(d0, 100, "ovr_done");
    check("ovr_accepts", dut_acc, 4);
    check("ovr_writes", log_data.size(), 4);
    check("ovr_offered_still", bus.psum_in_valid, 1);
    check("ovr_ready_low", bus.psum_in_ready, 0);
    check("ovr_idle", busy, 0);
    src_limit = 0;

    // Reset mid-RUN with two entries queued.
    sink_mode = 1;
    setup_source(2, 0, 16'h0400, 0);
    d0 = done_cnt;
    start_job(2, 1, 2, 2, 1);
    tick(6);
    check("rst_queued", dut_acc, 2);
    check("rst_pre_wr_en", bus.wr_en, 1);
    reset_n = 1'b0;
    tick(1);
    check("rst_ready", bus.psum_in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_await", bus.await, 0);
    check("rst_addr", bus.wr_addr, 0);
    check("rst_data", bus.wr_data, 0);
    tick(2);
    reset_n = 1'b1;
    sink_mode = 0;
    tick(5);
    check("rst_no_done", done_cnt, d0);
    check("rst_idle", busy, 0);

    // Randomized jobs with random valid/ready and occasional overrun.
    for (int j = 0; j < 10; j++) begin
      int f, nn, ee, pp, tt, tot;
      f  = $urandom_range(1, 3);
      nn = $urandom_range(1, 3);
      ee = $urandom_range(1, 3);
      pp = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
      tt = $urandom_range(1, 3);
      tot = f * nn * ee * pp * tt;
      sink_mode = 2;
      setup_source(tot + $urandom_range(0, 3), 1, DW'($urandom), 1);
      d0 = done_cnt;
      start_job(f, nn, ee, pp, tt);
      wait_done(d0, 8 * tot + 50, "rnd_done");
      check("rnd_writes", log_data.size(), tot);
      src_limit = 0;
      tick($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_writeback_collector.md
Name: psum_writeback_collector

Overview:
- Receive end of the psum path: takes psums streamed out of the PE array after the psum index generator has fed operands in.
- Buffers psums in a small FIFO and writes them to the global psum buffer at linear addresses.
- Attaches (psum, channel, row, col) indices using the same loop dimensions the generator uses.
- Drives `await` back to the index generator to throttle it when the FIFO is full.

Parameters:
DATA_WIDTH, 16, psum word width
F_WIDTH, 6, col dimension width
n_WIDTH, 3, psum (ofmap batch) dimension width
e_WIDTH, 8, row dimension width
p_WIDTH, 5, channels-per-pass width
t_WIDTH, 3, pass count width
ADDR_WIDTH, 25, buffer address width; must be >= F_WIDTH+n_WIDTH+e_WIDTH+p_WIDTH+t_WIDTH
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; all state updates on negedge clk, matching NoC controller timing
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
F  in  F_WIDTH  cols
n  in  n_WIDTH  psums
e  in  e_WIDTH  rows
p  in  p_WIDTH  channels per pass
t  in  t_WIDTH  passes
psum_in_valid  in  1  PE array psum valid
psum_in_data  in  DATA_WIDTH  psum value
psum_in_ready  out  1  collector accepts psum
await  out  1  backpressure to index generator: FIFO full
wr_en  out  1  buffer write request
wr_ready  in  1  buffer accepts write
wr_addr  out  ADDR_WIDTH  linear write address
wr_data  out  DATA_WIDTH  FIFO head
psum_index  out  n_WIDTH  n of current write
channel_index  out  p_WIDTH+t_WIDTH  p_idx + t_idx*p of current write
row_index  out  e_WIDTH  e of current write
col_index  out  F_WIDTH  F of current write
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n low): state IDLE; all counters, FIFO pointers and count = 0; all outputs 0.
- States:
  - IDLE: on start, latch F, n, e, p, t and go to LOAD.
  - LOAD (1 cycle): total = e*t*n*F*p, truncated to ADDR_WIDTH. If total==0 go to DONE; else go to RUN.
  - RUN: accept psums and write out. When in_cnt==total, go to DRAIN.
  - DRAIN: no new accepts; go to DONE when the write handshake with wr_cnt==total-1 completes.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in LOAD, RUN, DRAIN.
- Accept:
  - psum_in_ready = (state==RUN) && !full && (in_cnt<total).
  - Push on psum_in_valid && psum_in_ready; in_cnt increments.
  - Inputs beyond total are never accepted.
- await = full, in any state.
- Write:
  - wr_en = !empty, in RUN/DRAIN.
  - Pop on wr_en && wr_ready; wr_cnt increments.
  - wr_addr = wr_cnt; wr_data = FIFO head.
- Latency: a psum accepted at edge k can present wr_en after edge k. No bypass of an empty FIFO.
- Push and pop in the same cycle: count unchanged. Push while full is impossible (ready low). Pop while empty is impossible (wr_en low).
- Index counters advance on each pop.
  - Loop nest, innermost first: p_idx, F_idx, n_idx, t_idx, e_idx.
  - Each counter wraps to 0 at (dim-1) and carries to the next level.
  - wr_addr equals (((e_idx*t+t_idx)*n+n_idx)*F+F_idx)*p+p_idx by construction.
- Index outputs are combinational from the counters and valid whenever wr_en=1.
  - channel_index is computed in p_WIDTH+t_WIDTH bits.
- Config inputs are ignored after latching. start outside IDLE is ignored.
- Reset mid-job: everything aborted; FIFO contents discarded; no done pulse.

Decomposition:
- Shared package psum_pkg: collector state enum {IDLE, LOAD, RUN, DRAIN, DONE} and the default width localparams, shared with the index generator.
- One sub-module, psum_fifo: parameterized DATA_WIDTH/FIFO_DEPTH; push/pop/full/empty/count; same clock edge and reset.

Test Plan:
- Reset: assert reset_n=0 mid-RUN with 2 entries queued -> all outputs 0, psum_in_ready=0, done never pulses; after release, state IDLE.
- Basic job: F=2, n=1, e=2, p=2, t=1, 8 back-to-back psums 0x10..0x17, wr_ready=1.
  - wr_addr 0..7 with matching data.
  - (row,col,channel) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0),... 
  - done exactly one cycle after the 8th write.
- Backpressure: FIFO_DEPTH=4, wr_ready=0, continuous valid.
  - Exactly 4 accepted; then await=1 and psum_in_ready=0.
  - Raise wr_ready -> data drains in order; await drops after the first pop.
- Multi-pass: p=3, t=2, others 1 -> channel_index sequence 0,1,2,3,4,5; wr_addr 0..5.
- Zero dimension: p=0, start -> no wr_en; done 2 cycles after start (LOAD, DONE); busy high for 1 cycle.
- Overrun: total=4, source offers 6 valid psums -> only 4 accepted; psum_in_ready stays 0 after the 4th; start during RUN has no effect.
